// File: rtl/writeback_unit.sv
// Register-file write-back stage: merges single-cycle ALU results with
// load results buffered in a small FIFO. It also tracks which registers
// are waiting on an outstanding load, so the decoder can stall on
// load-use hazards.
module writeback_unit #(
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              alu_valid,
    input  logic [3:0]                        alu_rd,
    input  logic [31:0]                       alu_data,
    input  logic                              lsu_valid,
    output logic                              lsu_ready,
    input  logic [3:0]                        lsu_rd,
    input  logic [31:0]                       lsu_data,
    input  logic                              issue_valid,
    input  logic [3:0]                        issue_rd,
    output logic                              issue_ready,
    input  logic [3:0]                        query_loc_1,
    input  logic [3:0]                        query_loc_2,
    output logic                              hazard_1,
    output logic                              hazard_2,
    output logic                              do_write,
    output logic [3:0]                        write_loc,
    output logic [31:0]                       write_data,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } load_entry_t;

    load_entry_t      fifo_mem [LSU_FIFO_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;
    logic [15:0]      pending;

    logic             alu_commit;
    logic             push;
    logic             pop;
    load_entry_t      head_entry;
    logic [15:0]      set_mask;
    logic [15:0]      clear_mask;

    // ALU results win the write port; x0 results are dropped and never block a pop.
    assign alu_commit = alu_valid && (alu_rd != 4'd0);
    assign lsu_ready  = (count_q < CNT_W'(LSU_FIFO_DEPTH));
    // Loads to x0 are handshaken but never stored.
    assign push       = lsu_valid && lsu_ready && (lsu_rd != 4'd0);
    assign pop        = !alu_commit && (count_q != '0);
    assign head_entry = fifo_mem[head_ptr];
    assign fifo_count = count_q;

    assign issue_ready = (issue_rd == 4'd0) || !pending[issue_rd];
    assign hazard_1    = (query_loc_1 != 4'd0) && pending[query_loc_1];
    assign hazard_2    = (query_loc_2 != 4'd0) && pending[query_loc_2];

    // Scoreboard updates for this edge: new load issues set, load pops clear.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        set_mask   = '0;
        clear_mask = '0;
        if (issue_valid && issue_ready && (issue_rd != 4'd0))
            set_mask[issue_rd] = 1'b1;
        if (pop)
            clear_mask[head_entry.rd] = 1'b1;
    end

    // Load-result storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        // NOTE: the data array has no reset; validity is carried by the pointers and count, which are reset.
        if (push)
            fifo_mem[tail_ptr] <= '{rd: lsu_rd, data: lsu_data};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)
                head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered write port: ALU first, then FIFO head, else idle with held index/data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            do_write   <= 1'b0;
            write_loc  <= 4'd0;
            write_data <= 32'd0;
        end else if (alu_commit) begin
            do_write   <= 1'b1;
            write_loc  <= alu_rd;
            write_data <= alu_data;
        end else if (pop) begin
            do_write   <= 1'b1;
            write_loc  <= head_entry.rd;
            write_data <= head_entry.data;
        end else begin
            do_write   <= 1'b0;
        end
    end

    // Pending-load scoreboard; a clear and set of different registers both take effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending & ~clear_mask) | set_mask;
    end

endmodule
